// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Instruction-fetch front end. Owns the fetch PC, issues req/ready
//             fetches and feeds IF/ID through an output slot plus skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int PC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_freeze,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_addr,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ready,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_if_valid,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic [ADDR_W-1:0]  o_if_pc,
  output logic [ADDR_W-1:0]  o_fetch_pc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STALL  = 2'd2,
    S_SQUASH = 2'd3
  } state_t;

  state_t             r_state,       w_state_n;
  logic [ADDR_W-1:0]  r_fetch_pc,    w_fetch_pc_n;
  logic [ADDR_W-1:0]  r_redirect_pc, w_redirect_pc_n;
  logic               r_if_valid,    w_if_valid_n;
  logic [INSTR_W-1:0] r_if_instr,    w_if_instr_n;
  logic [ADDR_W-1:0]  r_if_pc,       w_if_pc_n;
  logic               r_skid_valid,  w_skid_valid_n;
  logic [INSTR_W-1:0] r_skid_instr,  w_skid_instr_n;
  logic [ADDR_W-1:0]  r_skid_pc,     w_skid_pc_n;

  logic [ADDR_W-1:0]  w_pc_plus;
  logic               w_slot_free;

  assign w_pc_plus   = r_fetch_pc + ADDR_W'(PC_STEP);
  assign w_slot_free = !r_if_valid || !i_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= '0;
      r_redirect_pc <= '0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc     <= '0;
    end else begin
      r_state       <= w_state_n;
      r_fetch_pc    <= w_fetch_pc_n;
      r_redirect_pc <= w_redirect_pc_n;
      r_if_valid    <= w_if_valid_n;
      r_if_instr    <= w_if_instr_n;
      r_if_pc       <= w_if_pc_n;
      r_skid_valid  <= w_skid_valid_n;
      r_skid_instr  <= w_skid_instr_n;
      r_skid_pc     <= w_skid_pc_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_fetch_pc_n    = r_fetch_pc;
    w_redirect_pc_n = r_redirect_pc;
    w_if_valid_n    = r_if_valid;
    w_if_instr_n    = r_if_instr;
    w_if_pc_n       = r_if_pc;
    w_skid_valid_n  = r_skid_valid;
    w_skid_instr_n  = r_skid_instr;
    w_skid_pc_n     = r_skid_pc;

    case (r_state)
      S_IDLE: begin
        w_state_n = S_FETCH;
        if (i_branch_taken) w_fetch_pc_n = i_branch_addr;
      end

      S_FETCH: begin
        if (i_branch_taken) begin
          w_if_valid_n = 1'b0;
          if (i_imem_ready) begin
            w_fetch_pc_n = i_branch_addr;
          end else begin
            // Memory still owes us a wrong-path word; wait it out in SQUASH.
            w_redirect_pc_n = i_branch_addr;
            w_state_n       = S_SQUASH;
          end
        end else if (i_imem_ready) begin
          w_fetch_pc_n = w_pc_plus;
          if (w_slot_free) begin
            w_if_instr_n = i_imem_rdata;
            w_if_pc_n    = w_pc_plus;
            w_if_valid_n = 1'b1;
            if (i_freeze) w_state_n = S_STALL;
          end else begin
            w_skid_instr_n = i_imem_rdata;
            w_skid_pc_n    = w_pc_plus;
            w_skid_valid_n = 1'b1;
            w_state_n      = S_STALL;
          end
        end else if (!i_freeze) begin
          w_if_valid_n = 1'b0;
        end
      end

      S_STALL: begin
        if (i_branch_taken) begin
          w_if_valid_n   = 1'b0;
          w_skid_valid_n = 1'b0;
          w_fetch_pc_n   = i_branch_addr;
          w_state_n      = S_FETCH;
        end else if (!i_freeze) begin
          if (r_skid_valid) begin
            w_if_instr_n   = r_skid_instr;
            w_if_pc_n      = r_skid_pc;
            w_if_valid_n   = 1'b1;
            w_skid_valid_n = 1'b0;
          end else begin
            w_if_valid_n = 1'b0;
          end
          w_state_n = S_FETCH;
        end
      end

      S_SQUASH: begin
        w_if_valid_n = 1'b0;
        if (i_imem_ready) begin
          w_fetch_pc_n = i_branch_taken ? i_branch_addr : r_redirect_pc;
          w_state_n    = S_FETCH;
        end else if (i_branch_taken) begin
          w_redirect_pc_n = i_branch_addr;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign o_imem_req  = (r_state == S_FETCH) || (r_state == S_SQUASH);
  assign o_imem_addr = r_fetch_pc;
  assign o_fetch_pc  = r_fetch_pc;
  assign o_if_valid  = r_if_valid;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc     = r_if_pc;

endmodule

`default_nettype wire
